// File: rtl/resolution_string_loader.sv
// resolution_string_loader
//   Tracks the active video mode id, debounces changes, and copies the
//   matching ASCII label into a registered line buffer one char per cycle
//   for the OSD text renderer.
//
//   Optional feature macro: RES_STRING_BLINK_EN
//     Adds input frame_tick and parameter BLINK_FRAMES. After every completed
//     load the label blinks (6 visibility toggles, one every BLINK_FRAMES
//     ticks) and then stays visible. Without the macro the label is always
//     visible and no blink logic exists.
//
//   Ports
//     clock      in   system/pixel clock, all logic on posedge
//     reset      in   asynchronous, active-high reset
//     mode_id    in   current video mode id (may glitch during mode detect)
//     rd_addr    in   char index for single-char read
//     frame_tick in   one-cycle pulse per frame (RES_STRING_BLINK_EN only)
//     rd_data    out  char at rd_addr, registered, 1-cycle latency
//     q          out  packed label, char 0 in the top CHAR_W bits
//     busy       out  high while debouncing or loading
//     updated    out  one-cycle pulse when a new label is complete
module resolution_string_loader #(
  parameter int NUM_MODES     = 3,
  parameter int MODE_W        = 4,
  parameter int CHARS         = 5,
  parameter int CHAR_W        = 8,
  parameter int STABLE_CYCLES = 16
`ifdef RES_STRING_BLINK_EN
  ,
  parameter int BLINK_FRAMES  = 30
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [MODE_W-1:0]          mode_id,
  input  logic [$clog2(CHARS)-1:0]   rd_addr,
`ifdef RES_STRING_BLINK_EN
  input  logic                       frame_tick,
`endif
  output logic [CHAR_W-1:0]          rd_data,
  output logic [CHARS*CHAR_W-1:0]    q,
  output logic                       busy,
  output logic                       updated
);

  localparam int AW = $clog2(CHARS);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int IW = $clog2(CHARS) + 1;

  localparam logic [CHAR_W-1:0] SPACE    = CHAR_W'(8'h20);
  localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(CHARS - 1);
  localparam logic [IW-1:0]     ADDR_LIM = IW'(CHARS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STABLE,
    LOAD,
    DONE
  } state_t;

  state_t              state_q;
  logic [MODE_W-1:0]   loaded_id_q;
  logic [MODE_W-1:0]   cand_q;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic                busy_q;
  logic                updated_q;
  logic [CHAR_W-1:0]   lbuf_q [CHARS];
  logic [CHAR_W-1:0]   rd_data_q;
  logic                vis;

  // Label table: base strings are 5 chars, right-aligned into CHARS slots
  // (extra slots on the left are spaces; a shorter CHARS drops leading chars).
  function automatic logic [CHAR_W-1:0] table_char(input int unsigned id,
                                                   input int unsigned pos);
    logic [39:0] s;
    logic [7:0]  c;
    int          p;
    case (id)
      0:       s = "1080p";
      1:       s = " 720p";
      2:       s = "  VGA";
      default: s = "?????";
    endcase
    p = int'(pos) - (CHARS - 5);
    if (id >= NUM_MODES)
      c = 8'h3F;
    else if (p < 0 || p > 4)
      c = 8'h20;
    else
      c = 8'(s >> (8 * (4 - p)));
    return CHAR_W'(c);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      loaded_id_q <= '1;
      cand_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      updated_q   <= 1'b0;
      for (int unsigned i = 0; i < CHARS; i++)
        lbuf_q[i] <= SPACE;
    end else begin
      updated_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mode_id != loaded_id_q) begin
            state_q <= WAIT_STABLE;
            cand_q  <= mode_id;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        WAIT_STABLE: begin
          if (mode_id != cand_q) begin
            cand_q <= mode_id;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            // A glitch that settled back on the current label needs no reload.
            if (cand_q == loaded_id_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= LOAD;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LOAD: begin
          lbuf_q[idx_q[AW-1:0]] <= table_char(32'(cand_q), 32'(idx_q));
          if (idx_q == IDX_LAST) begin
            state_q   <= DONE;
            updated_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          loaded_id_q <= cand_q;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RES_STRING_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [BW-1:0] TICK_LAST = BW'(BLINK_FRAMES - 1);

  logic          vis_q;
  logic          blink_on_q;
  logic [BW-1:0] tick_cnt_q;
  logic [2:0]    tog_q;

  // Armed on the cycle the updated pulse is visible; a fresh load cancels
  // any sequence still running so the new label starts visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vis_q      <= 1'b1;
      blink_on_q <= 1'b0;
      tick_cnt_q <= '0;
      tog_q      <= '0;
    end else if (updated_q) begin
      vis_q      <= 1'b1;
      blink_on_q <= 1'b1;
      tick_cnt_q <= '0;
      tog_q      <= '0;
    end else if (state_q == LOAD) begin
      vis_q      <= 1'b1;
      blink_on_q <= 1'b0;
    end else if (blink_on_q && frame_tick) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_q <= '0;
        vis_q      <= ~vis_q;
        tog_q      <= tog_q + 1'b1;
        if (tog_q == 3'd5)
          blink_on_q <= 1'b0;
      end else begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
    end
  end

  assign vis = vis_q;
`else
  assign vis = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rd_data_q <= SPACE;
    else if (vis && ({1'b0, rd_addr} < ADDR_LIM))
      rd_data_q <= lbuf_q[rd_addr];
    else
      rd_data_q <= SPACE;
  end

  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < CHARS; i++)
      q[(CHARS - 1 - i) * CHAR_W +: CHAR_W] = vis ? lbuf_q[i] : SPACE;
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign updated = updated_q;

endmodule

// File: tb/tb_resolution_string_loader.sv
module tb_resolution_string_loader;

  localparam int S   = 16;
  localparam int N   = 5;
  localparam int LAT = S + N + 1;

  logic        clock;
  logic        reset;
  logic [3:0]  mode_id;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [39:0] q;
  logic        busy;
  logic        updated;
`ifdef RES_STRING_BLINK_EN
  logic        frame_tick;
`endif

  int total = 0;
  int bad   = 0;
  int loaded_m = 15;

`ifdef RES_STRING_BLINK_EN
  resolution_string_loader #(.BLINK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .mode_id(mode_id), .rd_addr(rd_addr),
    .frame_tick(frame_tick), .rd_data(rd_data), .q(q), .busy(busy),
    .updated(updated));
`else
  resolution_string_loader dut (
    .clock(clock), .reset(reset), .mode_id(mode_id), .rd_addr(rd_addr),
    .rd_data(rd_data), .q(q), .busy(busy), .updated(updated));
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [39:0] exp_label(input int id);
    case (id)
      0:       return "1080p";
      1:       return " 720p";
      2:       return "  VGA";
      default: return "?????";
    endcase
  endfunction

  function automatic logic [7:0] exp_char(input int id, input int a);
    logic [39:0] l;
    if (a >= N) return 8'h20;
    l = exp_label(id);
    return l[8*(4-a) +: 8];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Run n edges after a mode change; report first edge with updated and pulse count.
  task automatic watch(input int n, output int first_n, output int pulses,
                       output logic busy1);
    first_n = -1;
    pulses  = 0;
    busy1   = 1'b0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 1) busy1 = busy;
      if (updated === 1'b1) begin
        pulses++;
        if (first_n < 0) first_n = k;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mode_id = 4'd0; rd_addr = 3'd0;
`ifdef RES_STRING_BLINK_EN
    frame_tick = 1'b0;
`endif
    #3 reset = 1'b1;
    #1;
    total++;
    if (q !== {5{8'h20}}) begin bad++; $display("FAIL reset_q: got %h expected %h", q, {5{8'h20}}); end
    total++;
    if (busy !== 1'b0 || updated !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got busy=%b updated=%b expected 0 0", busy, updated);
    end
    step();
    total++;
    if (rd_data !== 8'h20) begin bad++; $display("FAIL reset_rd: got %h expected 20", rd_data); end
  endtask

  task automatic test_first_load();
    int fn, pc; logic b1;
    mode_id = 4'd0;
    step();
    reset = 1'b0;
    watch(LAT + 4, fn, pc, b1);
    total++;
    if (fn !== LAT || pc !== 1) begin bad++; $display("FAIL first_latency: got edge=%0d pulses=%0d expected edge=%0d pulses=1", fn, pc, LAT); end
    total++;
    if (b1 !== 1'b1) begin bad++; $display("FAIL first_busy: got %b expected 1", b1); end
    total++;
    if (q !== exp_label(0) || busy !== 1'b0) begin bad++; $display("FAIL first_q: got %h busy=%b expected %h busy=0", q, busy, exp_label(0)); end
    loaded_m = 0;
  endtask

  task automatic test_glitch_return();
    int fn1, pc1, fn2, pc2; logic b1, b2;
    mode_id = 4'd1;
    watch(5, fn1, pc1, b1);
    mode_id = 4'd0;
    watch(S + 8, fn2, pc2, b2);
    total++;
    if (pc1 + pc2 !== 0) begin bad++; $display("FAIL glitch_updated: got %0d pulses expected 0", pc1 + pc2); end
    total++;
    if (b1 !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got start=%b end=%b expected 1 0", b1, busy); end
    total++;
    if (q !== exp_label(0)) begin bad++; $display("FAIL glitch_q: got %h expected %h", q, exp_label(0)); end
  endtask

  task automatic test_restart();
    int fn1, pc1, fn, pc; logic b1;
    mode_id = 4'd2;
    watch(11, fn1, pc1, b1);
    mode_id = 4'd1;
    watch(LAT + 4, fn, pc, b1);
    total++;
    if (pc1 !== 0 || fn !== LAT || pc !== 1) begin
      bad++; $display("FAIL restart_latency: got early=%0d edge=%0d pulses=%0d expected 0 %0d 1", pc1, fn, pc, LAT);
    end
    total++;
    if (q !== exp_label(1)) begin bad++; $display("FAIL restart_q: got %h expected %h", q, exp_label(1)); end
    loaded_m = 1;
  endtask

  task automatic test_unknown_id();
    int fn, pc; logic b1;
    int addrs [6] = '{2, 6, 0, 4, 5, 7};
    mode_id = 4'd7;
    watch(LAT + 4, fn, pc, b1);
    total++;
    if (fn !== LAT || q !== exp_label(7)) begin bad++; $display("FAIL unknown_q: got edge=%0d q=%h expected %0d %h", fn, q, LAT, exp_label(7)); end
    foreach (addrs[i]) begin
      rd_addr = 3'(addrs[i]);
      step();
      total++;
      if (rd_data !== exp_char(7, addrs[i])) begin
        bad++; $display("FAIL unknown_rd[%0d]: got %h expected %h", addrs[i], rd_data, exp_char(7, addrs[i]));
      end
    end
    loaded_m = 7;
  endtask

  task automatic test_reset_mid_load();
    int fn, pc; logic b1;
    logic [39:0] mixed;
    mode_id = 4'd0;
    watch(S + 3, fn, pc, b1);
    mixed = {exp_char(0, 0), exp_char(0, 1), exp_char(7, 2), exp_char(7, 3), exp_char(7, 4)};
    total++;
    if (q !== mixed || busy !== 1'b1) begin bad++; $display("FAIL midload_q: got %h busy=%b expected %h busy=1", q, busy, mixed); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (q !== {5{8'h20}} || busy !== 1'b0) begin bad++; $display("FAIL midload_reset: got %h busy=%b expected spaces busy=0", q, busy); end
    step();
    reset = 1'b0;
    watch(LAT + 4, fn, pc, b1);
    total++;
    if (fn !== LAT || pc !== 1 || q !== exp_label(0)) begin
      bad++; $display("FAIL midload_reload: got edge=%0d pulses=%0d q=%h expected %0d 1 %h", fn, pc, q, LAT, exp_label(0));
    end
    loaded_m = 0;
  endtask

  task automatic test_random();
    int fn, pc, gf, gp, ng, v, prev, tgt, a; logic b1, gb, any_diff, exp_busy1;
    for (int e = 0; e < 12; e++) begin
      prev = int'(mode_id);
      any_diff = 1'b0;
      gp = 0;
      exp_busy1 = 1'b0;
      ng = $urandom_range(0, 3);
      for (int g = 0; g < ng; g++) begin
        do v = $urandom_range(0, 8); while (v == prev);
        mode_id = 4'(v);
        prev = v;
        if (v != loaded_m) any_diff = 1'b1;
        watch($urandom_range(1, S - 1), gf, pc, gb);
        gp += pc;
      end
      do tgt = $urandom_range(0, 8); while (ng > 0 && tgt == prev);
      if (tgt != loaded_m) any_diff = 1'b1;
      exp_busy1 = any_diff;
      mode_id = 4'(tgt);
      watch(LAT + 5, fn, pc, b1);
      total++;
      if (gp !== 0) begin bad++; $display("FAIL rand%0d_glitch: got %0d pulses expected 0", e, gp); end
      total++;
      if (tgt != loaded_m) begin
        if (fn !== LAT || pc !== 1) begin bad++; $display("FAIL rand%0d_latency: got edge=%0d pulses=%0d expected %0d 1", e, fn, pc, LAT); end
      end else begin
        if (pc !== 0) begin bad++; $display("FAIL rand%0d_noload: got %0d pulses expected 0", e, pc); end
      end
      total++;
      if (b1 !== exp_busy1 || busy !== 1'b0) begin
        bad++; $display("FAIL rand%0d_busy: got start=%b end=%b expected %b 0", e, b1, busy, exp_busy1);
      end
      total++;
      if (q !== exp_label(tgt)) begin bad++; $display("FAIL rand%0d_q: got %h expected %h", e, q, exp_label(tgt)); end
      a = $urandom_range(0, 7);
      rd_addr = 3'(a);
      step();
      total++;
      if (rd_data !== exp_char(tgt, a)) begin bad++; $display("FAIL rand%0d_rd[%0d]: got %h expected %h", e, a, rd_data, exp_char(tgt, a)); end
      loaded_m = tgt;
    end
  endtask

`ifdef RES_STRING_BLINK_EN
  task automatic test_blink();
    int tgt, tog, k;
    bit seen;
    logic [39:0] exp_q;
    tgt = (loaded_m == 1) ? 2 : 1;
    mode_id = 4'(tgt);
    rd_addr = 3'd4;
    seen = 0;
    k = 0;
    while (!seen && k < 40) begin
      step();
      k++;
      if (updated === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL blink_load: got no updated within 40 cycles expected pulse"); end
    step();
    for (int t = 1; t <= 14; t++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      tog = (t / 2 > 6) ? 6 : t / 2;
      exp_q = (tog % 2 == 0) ? exp_label(tgt) : {5{8'h20}};
      total++;
      if (q !== exp_q || rd_data !== exp_q[7:0]) begin
        bad++; $display("FAIL blink_tick%0d: got q=%h rd=%h expected q=%h rd=%h", t, q, rd_data, exp_q, exp_q[7:0]);
      end
    end
    loaded_m = tgt;
  endtask
`endif

  initial begin
    test_reset();
    test_first_load();
    test_glitch_return();
    test_restart();
    test_unknown_id();
    test_reset_mid_load();
    test_random();
`ifdef RES_STRING_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
